slow_clock_monitor: RTL and testbench

Receiving end of the divided user clock. Samples the slow `usr_clk` square wave in the fast `clk` domain and emits a one-cycle `tick` on each rising edge. Measures the period between rising edges in `clk` cycles and flags periods outside tolerance. Flags loss of the slow clock. Downstream timekeeping logic uses `tick` instead of clocking flops from `usr_clk`.

---
 rtl/slow_clock_monitor.sv | 121 ++++++++++++
 tb/tb_slow_clock_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/slow_clock_monitor.sv
// Samples a slow divided clock in the clk domain, emits a tick per rising edge,
// measures the rise-to-rise period and flags out-of-tolerance periods and loss of the clock.
module slow_clock_monitor #(
    parameter int CNT_W      = 28,
    parameter int EXP_PERIOD = 100002,
    parameter int TOL        = 16,
    parameter int TIMEOUT    = 200000,
    parameter int EC_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             usr_clk,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_tol,
    output logic             lost,
    output logic [EC_W-1:0]  edge_count
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic signed [CNT_W:0] EXP_S   = (CNT_W+1)'(EXP_PERIOD);
    localparam logic signed [CNT_W:0] TOL_S   = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0]      TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s1, s2, s3;
    logic              rise;
    logic              tick_d, period_valid_d, in_tol_d, lost_d;
    logic [CNT_W-1:0]  period_d;
    logic [EC_W-1:0]   edge_count_d;
    logic signed [CNT_W:0] diff;
    logic              tol_ok;

    // Sync flops reset to 0 so a clock already high at reset release reads as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= usr_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise   = s2 & ~s3;
    assign diff   = $signed({1'b0, cnt_q}) - EXP_S;
    assign tol_ok = (diff >= -TOL_S) && (diff <= TOL_S);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tick         <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            in_tol       <= 1'b0;
            lost         <= 1'b0;
            edge_count   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick         <= tick_d;
            period       <= period_d;
            period_valid <= period_valid_d;
            in_tol       <= in_tol_d;
            lost         <= lost_d;
            edge_count   <= edge_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tick_d         = rise;
        period_d       = period;
        period_valid_d = 1'b0;
        in_tol_d       = in_tol;
        lost_d         = lost;
        edge_count_d   = edge_count;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    edge_count_d = edge_count + EC_W'(1);
                    state_d      = MEASURE;
                    cnt_d        = CNT_W'(1);
                end
            end
            MEASURE: begin
                // A rise on the timeout cycle still counts as a valid period.
                if (rise) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    in_tol_d       = tol_ok;
                    cnt_d          = CNT_W'(1);
                    edge_count_d   = edge_count + EC_W'(1);
                    lost_d         = 1'b0;
                end else if (cnt_q == TIMEOUT_C) begin
                    lost_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor with short sim parameters (period 10, tol 1, timeout 25).
module tb_slow_clock_monitor;

    localparam int CNT_W = 28;
    localparam int EC_W  = 4;

    logic             clk;
    logic             reset;
    logic             usr_clk;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             in_tol;
    logic             lost;
    logic [EC_W-1:0]  edge_count;

    int checks   = 0;
    int failures = 0;
    int tick_total = 0;

    typedef struct {
        int p;
        bit pv;
        int per;
        bit tol;
        bit lst;
        int ec;
    } vec_t;

    vec_t tv[11];

    slow_clock_monitor #(
        .CNT_W(CNT_W),
        .EXP_PERIOD(10),
        .TOL(1),
        .TIMEOUT(25),
        .EC_W(EC_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .usr_clk(usr_clk),
        .tick(tick),
        .period(period),
        .period_valid(period_valid),
        .in_tol(in_tol),
        .lost(lost),
        .edge_count(edge_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (tick) tick_total++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tick"}, longint'(tick), 0);
        chk({tag, "_period"}, longint'(period), 0);
        chk({tag, "_pv"}, longint'(period_valid), 0);
        chk({tag, "_in_tol"}, longint'(in_tol), 0);
        chk({tag, "_lost"}, longint'(lost), 0);
        chk({tag, "_ec"}, longint'(edge_count), 0);
    endtask

    // Raise usr_clk, hold it for p/2 samples, low for the rest; rise-to-rise is p cycles.
    task automatic apply_vec(input vec_t v, input string tag);
        usr_clk = 1'b1;
        for (int i = 1; i <= v.p; i++) begin
            step();
            if (i == v.p / 2) usr_clk = 1'b0;
            if (i == 2) chk({tag, "_early_tick"}, longint'(tick), 0);
            if (i == 3) begin
                chk({tag, "_tick"}, longint'(tick), 1);
                chk({tag, "_pv"}, longint'(period_valid), longint'(v.pv));
                chk({tag, "_period"}, longint'(period), longint'(v.per));
                chk({tag, "_in_tol"}, longint'(in_tol), longint'(v.tol));
                chk({tag, "_lost"}, longint'(lost), longint'(v.lst));
                chk({tag, "_ec"}, longint'(edge_count), longint'(v.ec));
            end
            if (i == 4) begin
                chk({tag, "_tick_pulse"}, longint'(tick), 0);
                chk({tag, "_pv_pulse"}, longint'(period_valid), 0);
            end
        end
    endtask

    initial begin
        int t0;
        tv[0]  = '{10, 1'b0, 0,  1'b0, 1'b0, 1};
        tv[1]  = '{10, 1'b1, 10, 1'b1, 1'b0, 2};
        tv[2]  = '{10, 1'b1, 10, 1'b1, 1'b0, 3};
        tv[3]  = '{11, 1'b1, 10, 1'b1, 1'b0, 4};
        tv[4]  = '{12, 1'b1, 11, 1'b1, 1'b0, 5};
        tv[5]  = '{9,  1'b1, 12, 1'b0, 1'b0, 6};
        tv[6]  = '{10, 1'b1, 9,  1'b1, 1'b0, 7};
        // after the loss: restart, then a 25-cycle period that lands on the timeout cycle
        tv[7]  = '{10, 1'b0, 10, 1'b1, 1'b1, 9};
        tv[8]  = '{25, 1'b1, 10, 1'b1, 1'b0, 10};
        tv[9]  = '{10, 1'b1, 25, 1'b0, 1'b0, 11};
        tv[10] = '{10, 1'b1, 10, 1'b1, 1'b0, 12};

        reset   = 1'b1;
        usr_clk = 1'b0;
        repeat (3) step();
        chk_zero("reset");
        reset = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 7; i++) apply_vec(tv[i], $sformatf("v%0d", i));

        // loss of clock: last tick, then usr_clk held low
        usr_clk = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 5) usr_clk = 1'b0;
            if (i == 3) begin
                chk("loss_tick", longint'(tick), 1);
                chk("loss_period_in", longint'(period), 10);
                chk("loss_ec", longint'(edge_count), 8);
            end
            if (i == 27) chk("lost_early", longint'(lost), 0);
            if (i == 28) begin
                chk("lost_set", longint'(lost), 1);
                chk("lost_period_kept", longint'(period), 10);
                chk("lost_pv", longint'(period_valid), 0);
                chk("lost_in_tol_kept", longint'(in_tol), 1);
            end
        end
        chk("lost_no_tick", longint'(tick_total), 8);

        for (int i = 7; i < 11; i++) apply_vec(tv[i], $sformatf("v%0d", i));

        // reset in the middle of a high phase
        usr_clk = 1'b1;
        repeat (4) step();
        reset = 1'b1;
        step();
        chk_zero("mid_reset");
        step();
        chk("mid_reset2_ec", longint'(edge_count), 0);
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 5) usr_clk = 1'b0;
            if (i == 2) chk("post_reset_early_tick", longint'(tick), 0);
            if (i == 3) begin
                chk("post_reset_tick", longint'(tick), 1);
                chk("post_reset_pv", longint'(period_valid), 0);
                chk("post_reset_period", longint'(period), 0);
                chk("post_reset_ec", longint'(edge_count), 1);
            end
            if (i == 4) chk("post_reset_pv2", longint'(period_valid), 0);
        end
        apply_vec('{10, 1'b1, 10, 1'b1, 1'b0, 2}, "post_reset_next");

        // edge_count wrap over 17 edges
        reset   = 1'b1;
        usr_clk = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
        t0 = tick_total;
        for (int j = 1; j <= 17; j++) begin
            vec_t v;
            v.p   = 10;
            v.pv  = (j > 1);
            v.per = (j > 1) ? 10 : 0;
            v.tol = (j > 1);
            v.lst = 1'b0;
            v.ec  = j % 16;
            apply_vec(v, $sformatf("wrap%0d", j));
        end
        chk("wrap_tick_count", longint'(tick_total - t0), 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
